// File: rtl/zap_wb_arbiter_n.sv
// Round-robin Wishbone arbiter: merges NUM_CH next-cycle requester buses onto one
// registered common bus, holding the grant through bursts and unacknowledged cycles.
module zap_wb_arbiter_n #(
    parameter int NUM_CH = 3,
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    input  logic [NUM_CH-1:0]     i_wb_cyc,
    input  logic [NUM_CH-1:0]     i_wb_stb,
    input  logic [NUM_CH-1:0]     i_wb_wen,
    input  logic [4*NUM_CH-1:0]   i_wb_sel,
    input  logic [32*NUM_CH-1:0]  i_wb_dat,
    input  logic [32*NUM_CH-1:0]  i_wb_adr,
    input  logic [3*NUM_CH-1:0]   i_wb_cti,
    output logic [NUM_CH-1:0]     o_wb_ack,

    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_wen,
    output logic [3:0]            o_wb_sel,
    output logic [31:0]           o_wb_dat,
    output logic [31:0]           o_wb_adr,
    output logic [2:0]            o_wb_cti,
    input  logic                  i_wb_ack,

    output logic [NUM_CH-1:0]     o_grant
);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    logic [GW-1:0] grant_ff;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] idx;
    logic          unlocked;
    logic          found;

    // The bus may change hands only when idle or on the terminating ack of a cycle.
    assign unlocked = !o_wb_stb | (i_wb_ack & ((o_wb_cti == CTI_EOB) | (o_wb_cti == CTI_CLASSIC)));

    // Search starts just past the current holder, so the holder ranks last at release.
    always_comb begin
        grant_nxt = grant_ff;
        found     = 1'b0;
        idx       = '0;
        if (unlocked) begin
            for (int off = 1; off <= NUM_CH; off++) begin
                idx = GW'((int'(grant_ff) + off) % NUM_CH);
                if (!found && i_wb_stb[idx]) begin
                    grant_nxt = idx;
                    found     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_sel <= '0;
            o_wb_dat <= '0;
            o_wb_adr <= '0;
            o_wb_cti <= CTI_EOB;
            grant_ff <= '0;
        end else begin
            o_wb_cyc <= i_wb_cyc[grant_nxt];
            o_wb_stb <= i_wb_stb[grant_nxt];
            o_wb_wen <= i_wb_wen[grant_nxt];
            o_wb_sel <= i_wb_sel[grant_nxt*4 +: 4];
            o_wb_dat <= i_wb_dat[grant_nxt*32 +: 32];
            o_wb_adr <= i_wb_adr[grant_nxt*32 +: 32];
            o_wb_cti <= i_wb_cti[grant_nxt*3 +: 3];
            grant_ff <= grant_nxt;
        end
    end

    always_comb begin
        o_wb_ack = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            o_wb_ack[k] = i_wb_ack & o_wb_stb & (grant_ff == GW'(k));
        end
    end

    assign o_grant = NUM_CH'(1) << grant_ff;

endmodule

// File: tb/tb_zap_wb_arbiter_n.sv
// Directed bench for zap_wb_arbiter_n (3 channels): reset/idle, classic write,
// burst lock with handover, round-robin fairness, stray ack and reset mid-burst.
module tb_zap_wb_arbiter_n;

    localparam int NUM_CH = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    wb_cyc, wb_stb, wb_wen;
    logic [4*NUM_CH-1:0]  wb_sel;
    logic [32*NUM_CH-1:0] wb_dat, wb_adr;
    logic [3*NUM_CH-1:0]  wb_cti;
    logic [NUM_CH-1:0]    ack_ch;
    logic                 bus_cyc, bus_stb, bus_wen;
    logic [3:0]           bus_sel;
    logic [31:0]          bus_dat, bus_adr;
    logic [2:0]           bus_cti;
    logic                 bus_ack;
    logic [NUM_CH-1:0]    grant;

    int n_cmp = 0;
    int n_err = 0;
    int acks [NUM_CH];

    always #5 clk = ~clk;

    zap_wb_arbiter_n #(.NUM_CH(NUM_CH)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_wb_cyc (wb_cyc),
        .i_wb_stb (wb_stb),
        .i_wb_wen (wb_wen),
        .i_wb_sel (wb_sel),
        .i_wb_dat (wb_dat),
        .i_wb_adr (wb_adr),
        .i_wb_cti (wb_cti),
        .o_wb_ack (ack_ch),
        .o_wb_cyc (bus_cyc),
        .o_wb_stb (bus_stb),
        .o_wb_wen (bus_wen),
        .o_wb_sel (bus_sel),
        .o_wb_dat (bus_dat),
        .o_wb_adr (bus_adr),
        .o_wb_cti (bus_cti),
        .i_wb_ack (bus_ack),
        .o_grant  (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 2 time units after the edge, outputs sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_ch(input int k, input logic stb, input logic wen, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
        wb_cyc[k]          = stb;
        wb_stb[k]          = stb;
        wb_wen[k]          = wen;
        wb_adr[32*k +: 32] = adr;
        wb_dat[32*k +: 32] = dat;
        wb_sel[4*k +: 4]   = sel;
        wb_cti[3*k +: 3]   = cti;
    endtask

    initial begin
        rst = 1'b1;
        wb_cyc = '0; wb_stb = '0; wb_wen = '0; wb_sel = '0;
        wb_dat = '0; wb_adr = '0; wb_cti = '0; bus_ack = 1'b0;
        for (int k = 0; k < NUM_CH; k++) acks[k] = 0;

        // Reset then idle
        next_cycle();
        next_cycle();
        rst = 1'b0;
        settle();
        chk("rst_stb", 32'(bus_stb), 32'd0);
        chk("rst_cyc", 32'(bus_cyc), 32'd0);
        chk("rst_adr", bus_adr, 32'h0);
        chk("rst_dat", bus_dat, 32'h0);
        chk("rst_sel", 32'(bus_sel), 32'h0);
        chk("rst_cti", 32'(bus_cti), 32'd7);
        chk("rst_grant", 32'(grant), 32'b001);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            settle();
            chk("idle_stb", 32'(bus_stb), 32'd0);
            chk("idle_grant", 32'(grant), 32'b001);
            chk("idle_ack", 32'(ack_ch), 32'd0);
        end

        // Stray ack while the bus is idle
        next_cycle();
        bus_ack = 1'b1;
        settle();
        chk("stray_ack", 32'(ack_ch), 32'd0);
        next_cycle();
        bus_ack = 1'b0;
        settle();
        chk("stray_grant", 32'(grant), 32'b001);
        chk("stray_stb", 32'(bus_stb), 32'd0);

        // Single classic write on ch1
        next_cycle();
        set_ch(1, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'b000);
        next_cycle();
        settle();
        chk("cw_adr", bus_adr, 32'h1000);
        chk("cw_dat", bus_dat, 32'hDEADBEEF);
        chk("cw_wen", 32'(bus_wen), 32'd1);
        chk("cw_grant", 32'(grant), 32'b010);
        chk("cw_ack_wait", 32'(ack_ch), 32'd0);
        next_cycle();
        bus_ack = 1'b1;
        set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        settle();
        chk("cw_ack", 32'(ack_ch), 32'b010);
        chk("cw_hold_adr", bus_adr, 32'h1000);
        next_cycle();
        bus_ack = 1'b0;
        settle();
        chk("cw_end_stb", 32'(bus_stb), 32'd0);
        chk("cw_end_grant", 32'(grant), 32'b010);

        // ch0 4-beat burst; ch2 requests mid-burst and takes over without a bubble
        next_cycle();
        set_ch(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010);
        next_cycle();
        bus_ack = 1'b1;
        set_ch(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 3'b010);
        settle();
        chk("b0_adr", bus_adr, 32'h0);
        chk("b0_grant", 32'(grant), 32'b001);
        chk("b0_ack", 32'(ack_ch), 32'b001);
        next_cycle();
        set_ch(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'b010);
        set_ch(2, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 3'b000);
        settle();
        chk("b1_adr", bus_adr, 32'h4);
        chk("b1_ack", 32'(ack_ch), 32'b001);
        next_cycle();
        set_ch(0, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF, 3'b111);
        settle();
        chk("b2_adr", bus_adr, 32'h8);
        chk("b2_grant", 32'(grant), 32'b001);
        next_cycle();
        set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        settle();
        chk("b3_adr", bus_adr, 32'hC);
        chk("b3_cti", 32'(bus_cti), 32'd7);
        chk("b3_ack", 32'(ack_ch), 32'b001);
        next_cycle();
        set_ch(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        settle();
        chk("ho_adr", bus_adr, 32'h2000);
        chk("ho_stb", 32'(bus_stb), 32'd1);
        chk("ho_grant", 32'(grant), 32'b100);
        chk("ho_ack", 32'(ack_ch), 32'b100);
        next_cycle();
        bus_ack = 1'b0;
        settle();
        chk("ho_end_stb", 32'(bus_stb), 32'd0);

        // Round-robin from grant 0: all channels request continuously, slave acks every cycle
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            set_ch(k, 1'b1, 1'b0, 32'h100 * k, 32'h0, 4'hF, 3'b000);
        settle();
        chk("rr_start_grant", 32'(grant), 32'b001);
        for (int i = 1; i <= 30; i++) begin
            next_cycle();
            bus_ack = 1'b1;
            settle();
            chk("rr_grant", 32'(grant), 32'(3'b001 << (i % 3)));
            chk("rr_adr", bus_adr, 32'h100 * (i % 3));
            for (int k = 0; k < NUM_CH; k++)
                if (ack_ch[k]) acks[k]++;
        end
        chk("rr_acks_ch0", 32'(acks[0]), 32'd10);
        chk("rr_acks_ch1", 32'(acks[1]), 32'd10);
        chk("rr_acks_ch2", 32'(acks[2]), 32'd10);
        next_cycle();
        for (int k = 0; k < NUM_CH; k++)
            set_ch(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        settle();
        chk("rr_tail_grant", 32'(grant), 32'b010);
        next_cycle();
        bus_ack = 1'b0;
        settle();
        chk("rr_idle_stb", 32'(bus_stb), 32'd0);

        // Reset during beat 2 of a ch2 burst, then a normal ch1 request
        next_cycle();
        set_ch(2, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 3'b010);
        next_cycle();
        bus_ack = 1'b1;
        set_ch(2, 1'b1, 1'b0, 32'h3004, 32'h0, 4'hF, 3'b010);
        settle();
        chk("mr_b0_adr", bus_adr, 32'h3000);
        chk("mr_b0_grant", 32'(grant), 32'b100);
        next_cycle();
        set_ch(2, 1'b1, 1'b0, 32'h3008, 32'h0, 4'hF, 3'b010);
        settle();
        chk("mr_b1_adr", bus_adr, 32'h3004);
        next_cycle();
        bus_ack = 1'b0;
        rst = 1'b1;
        settle();
        chk("mr_b2_adr", bus_adr, 32'h3008);
        next_cycle();
        rst = 1'b0;
        set_ch(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        set_ch(1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF, 3'b000);
        settle();
        chk("mr_rst_stb", 32'(bus_stb), 32'd0);
        chk("mr_rst_cti", 32'(bus_cti), 32'd7);
        chk("mr_rst_grant", 32'(grant), 32'b001);
        chk("mr_rst_ack", 32'(ack_ch), 32'd0);
        next_cycle();
        bus_ack = 1'b1;
        set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        settle();
        chk("mr_ch1_adr", bus_adr, 32'h4000);
        chk("mr_ch1_grant", 32'(grant), 32'b010);
        chk("mr_ch1_ack", 32'(ack_ch), 32'b010);
        next_cycle();
        bus_ack = 1'b0;
        settle();
        chk("mr_end_stb", 32'(bus_stb), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
